// File: rtl/pipeline_control.sv
// Pipeline sequencing for the MIPS core: per-latch enable/flush/valid, memory and
// fetch stalls, load-use bubbles, redirect squash and the halt drain sequence.
module pipeline_control #(
   parameter int NLATCH       = 4,
   parameter int MEM_LATCH    = 2,
   parameter int BRANCH_LATCH = 2,
   parameter int LU_STALLS    = 1,
   parameter int CNT_W        = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              mem_req,
   input  logic              load_use,
   input  logic              redirect,
   input  logic              halt_req,
   output logic              pc_en,
   output logic [NLATCH-1:0] lat_en,
   output logic [NLATCH-1:0] lat_flush,
   output logic [NLATCH-1:0] lat_valid,
   output logic              halt,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [NLATCH-1:0] valid_q, valid_d;
   logic [2:0]        lu_cnt_q, lu_cnt_d;
   logic              lu_act_q, lu_act_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              halt_q;

   logic              mem_v, red_v, hlt_v, dstall, upper_busy;
   logic              pc_en_c;
   logic [NLATCH-1:0] en_c, flush_c;

   // Requests only count when the instruction raising them is real.
   assign mem_v  = mem_req & valid_q[MEM_LATCH];
   assign red_v  = redirect & valid_q[BRANCH_LATCH];
   assign hlt_v  = halt_req & valid_q[BRANCH_LATCH];
   assign dstall = mem_v & ~dhit;

   always_comb begin
      pc_en_c     = 1'b0;
      en_c        = '1;
      flush_c     = '0;
      state_d     = state_q;
      lu_cnt_d    = lu_cnt_q;
      lu_act_d    = lu_act_q;
      valid_d     = valid_q;
      stall_cnt_d = stall_cnt_q;
      upper_busy  = 1'b0;

      if (state_q == HALTED) begin
         en_c = '0;
      end else if (dstall) begin
         for (int i = 0; i < NLATCH; i++) begin
            if (i <= MEM_LATCH) en_c[i] = 1'b0;
            else                flush_c[i] = 1'b1;
         end
      end else if (state_q == DRAIN || hlt_v) begin
         for (int i = 0; i <= BRANCH_LATCH; i++) flush_c[i] = 1'b1;
         lu_cnt_d = '0;
         lu_act_d = 1'b0;
         if (state_q == RUN) state_d = DRAIN;
      end else if (red_v) begin
         pc_en_c = 1'b1;
         for (int i = 0; i <= BRANCH_LATCH; i++) flush_c[i] = 1'b1;
         lu_cnt_d = '0;
         lu_act_d = 1'b0;
      end else if (lu_act_q || load_use) begin
         en_c[0]    = 1'b0;
         flush_c[1] = 1'b1;
         // The trigger cycle is the first bubble; the counter holds the ones still owed.
         if (lu_act_q) begin
            lu_cnt_d = lu_cnt_q - 3'd1;
            lu_act_d = (lu_cnt_q > 3'd1);
         end else begin
            lu_cnt_d = 3'(LU_STALLS - 1);
            lu_act_d = (LU_STALLS > 1);
         end
      end else if (!ihit) begin
         flush_c[0] = 1'b1;
      end else begin
         pc_en_c = 1'b1;
      end

      valid_d[0] = en_c[0] ? (ihit & ~flush_c[0]) : valid_q[0];
      for (int i = 1; i < NLATCH; i++)
         valid_d[i] = en_c[i] ? (valid_q[i-1] & ~flush_c[i]) : valid_q[i];

      for (int i = BRANCH_LATCH + 1; i < NLATCH; i++) upper_busy = upper_busy | valid_d[i];
      if (state_q == DRAIN && !dstall && !upper_busy) state_d = HALTED;

      if (state_q == RUN && !pc_en_c && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= RUN;
         valid_q     <= '0;
         lu_cnt_q    <= '0;
         lu_act_q    <= 1'b0;
         stall_cnt_q <= '0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         lu_cnt_q    <= lu_cnt_d;
         lu_act_q    <= lu_act_d;
         stall_cnt_q <= stall_cnt_d;
         halt_q      <= (state_d == HALTED);
      end
   end

   // While reset is held every latch is forced to a bubble and nothing advances.
   assign pc_en     = nRST & pc_en_c;
   assign lat_en    = nRST ? en_c : '0;
   assign lat_flush = nRST ? flush_c : '1;
   assign lat_valid = valid_q;
   assign halt      = halt_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Parametrised pipeline sequencing block for the MIPS pipelined core.
- Replaces the free-running latch clocking with per-latch enable/flush, per-latch valid tracking, memory-wait stalls, load-use bubbles, redirect squash and a halt drain FSM.
- Sits beside the datapath and drives the enable/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and of the PC.

Parameters:
- NLATCH, 4: number of pipeline latches; index 0 = IF/ID ... NLATCH-1 = MEM/WB.
- MEM_LATCH, 2: index of the latch whose output instruction accesses data memory (EX/MEM).
- BRANCH_LATCH, 2: index of the latch whose output resolves branches and jumps.
- LU_STALLS, 1: bubble cycles inserted per load-use hazard (1..7).
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_req  in  1  instruction at MEM_LATCH output issues dmemREN or dmemWEN.
- load_use  in  1  decode detects a consumer of the load in ID/EX.
- redirect  in  1  taken branch, jump or jr resolved at BRANCH_LATCH output.
- halt_req  in  1  halt instruction present at BRANCH_LATCH output.
- pc_en  out  1  PC register load enable.
- lat_en  out  NLATCH  per-latch capture enable.
- lat_flush  out  NLATCH  per-latch bubble load (control zeroed, valid cleared).
- lat_valid  out  NLATCH  per-latch valid bit.
- halt  out  1  sticky halt to cache/system.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 while in RUN.

Behaviour:
- Reset (async): state=RUN, lat_valid=0, lu counter=0, stall_cnt=0, halt=0. Combinational outputs at reset: pc_en=0, lat_en=0, lat_flush=all ones.
- The mem_req, redirect and halt_req inputs are qualified by the valid bit of their latch. Unqualified assertions are ignored.
- Dstall = valid mem_req & ~dhit:
  - lat_en[0..MEM_LATCH]=0 and pc_en=0.
  - Latches above MEM_LATCH load bubbles (lat_flush=1, lat_en=1).
  - Dstall has top priority. redirect, load_use and halt_req are held off until dhit.
- Istall = ~ihit with no Dstall: pc_en=0. Latch 0 loads a bubble. Older latches advance.
- Load-use with no Dstall and no redirect:
  - The lu counter loads LU_STALLS-1 and sets an active flag.
  - For LU_STALLS cycles: pc_en=0, lat_en[0]=0, latch 1 loads a bubble, latches ≥2 advance.
  - load_use asserted while the counter is active does not retrigger.
- Redirect with no Dstall:
  - pc_en=1 (target loads).
  - Latches 0..BRANCH_LATCH load bubbles.
  - Any active load-use sequence is cancelled.
  - Redirect wins over Istall and load_use in the same cycle.
- Normal advance: all lat_en=1, lat_flush=0. Each lat_valid[i] ← lat_valid[i-1]; lat_valid[0] ← 1 on ihit.
- Flushed latch: valid ← 0. Held latch: valid unchanged.
- FSM:
  - RUN → DRAIN on qualified halt_req with no Dstall. That edge flushes latches 0..BRANCH_LATCH, and pc_en=0 from then on.
  - DRAIN: pc_en=0. Latches below BRANCH_LATCH+1 stay flushed. Older latches advance (Dstall still applies) until lat_valid[BRANCH_LATCH+1..NLATCH-1] are all 0.
  - DRAIN → HALTED when that condition holds.
  - HALTED: halt=1, pc_en=0, all lat_en=0. Stays until reset.
  - halt and redirect in the same cycle: halt wins.
- stall_cnt increments on each RUN cycle with pc_en=0 and saturates at 2^CNT_W-1.
- Reset asserted mid-stall or mid-drain returns to the reset state immediately.

Test Plan:
- Reset then ihit=1 constant: lat_valid fills 0001→0011→0111→1111 over 4 cycles; pc_en=1 every cycle; stall_cnt=0.
- Load at EX/MEM with mem_req=1, dhit low for 3 cycles: lat_en=1000 (only MEM/WB enabled, as bubble) and pc_en=0 for 3 cycles; lat_valid[3]=0 after them; stall_cnt=3; everything advances on the dhit cycle.
- load_use pulse with LU_STALLS=2: pc_en=0 and latch 1 flushed for exactly 2 cycles; a second load_use in cycle 2 is ignored.
- redirect and load_use together: pc_en=1; latches 0..2 flushed; no bubble sequence follows.
- halt_req valid with a store pending in MEM/WB: DRAIN for 1 cycle, then halt=1 sticky; pc_en stays 0 through 20 further cycles.
- nRST low during Dstall: outputs return to reset values asynchronously; stall_cnt=0.
